// File: rtl/pixie_pkg.sv
// Shared constants and types for the Studio II 1861-style video fetch path.
// The pixel serialiser imports the same constants.
package pixie_pkg;

  localparam int unsigned BYTES_PER_ROW  = 8;
  localparam int unsigned LINE_REPEAT    = 4;
  localparam int unsigned ROWS_PER_FRAME = 32;
  localparam logic [15:0] START_ADDR     = 16'h0900;
  localparam logic [1:0]  SC_DMA         = 2'b10;
  localparam int unsigned ROW_IDX_W      = 3;

  typedef enum logic [1:0] {
    StIdle,
    StArm,
    StFetch,
    StDone
  } fetch_state_e;

  // Advance a display-RAM address; the page (high byte) never changes.
  function automatic logic [15:0] next_addr(input logic [15:0] addr);
    return {addr[15:8], addr[7:0] + 8'd1};
  endfunction

endpackage

// File: rtl/pixie_dma_fetch_if.sv
// CDP1802 bus-side signals seen by the DMA fetch stage.
// master = CPU side, slave = fetch stage.
interface pixie_dma_fetch_if;

  logic        clk_enable;
  logic [1:0]  SC;
  logic [7:0]  data_in;
  logic        DMAO;
  logic [15:0] mem_addr;

  modport master (
    output clk_enable,
    output SC,
    output data_in,
    input  DMAO,
    input  mem_addr
  );

  modport slave (
    input  clk_enable,
    input  SC,
    input  data_in,
    output DMAO,
    output mem_addr
  );

endinterface

// File: rtl/pixie_row_buffer.sv
// Ping-pong row buffer: two banks of one display row each. One bank is
// written by the DMA fetch while the other is read combinationally.
module pixie_row_buffer
  import pixie_pkg::*;
(
  input  logic                 clk,
  input  logic                 we,
  input  logic                 wr_bank,
  input  logic [ROW_IDX_W-1:0] wr_idx,
  input  logic [7:0]           wr_data,
  input  logic                 rd_bank,
  input  logic [ROW_IDX_W-1:0] rd_idx,
  output logic [7:0]           rd_data
);

  localparam int unsigned Depth = 1 << ROW_IDX_W;

  logic [7:0] mem [2][Depth];

  // Storage is not reset; validity is tracked by the fetch controller.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_bank][wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem[rd_bank][rd_idx];

endmodule

// File: rtl/pixie_dma_fetch.sv
// Row-fetch stage for the 1861-style video generator: requests CPU DMA-out
// cycles once per displayed row group, captures the row into a ping-pong
// buffer and swaps banks when the row group ends.
module pixie_dma_fetch
  import pixie_pkg::fetch_state_e, pixie_pkg::StIdle, pixie_pkg::StArm,
         pixie_pkg::StFetch, pixie_pkg::StDone, pixie_pkg::SC_DMA,
         pixie_pkg::next_addr;
#(
  parameter int unsigned BYTES_PER_ROW  = pixie_pkg::BYTES_PER_ROW,
  parameter int unsigned LINE_REPEAT    = pixie_pkg::LINE_REPEAT,
  parameter int unsigned ROWS_PER_FRAME = pixie_pkg::ROWS_PER_FRAME,
  parameter logic [15:0] START_ADDR     = pixie_pkg::START_ADDR
) (
  input  logic             clk,
  input  logic             reset,
  pixie_dma_fetch_if.slave bus,
  input  logic             disp_on,
  input  logic             disp_off,
  input  logic             frame_start,
  input  logic             line_start,
  input  logic [2:0]       rd_idx,
  output logic [7:0]       row_byte,
  output logic             row_valid,
  output logic             display_enabled,
  output logic             overrun
);

  localparam int unsigned LineCntW = (LINE_REPEAT > 1) ? $clog2(LINE_REPEAT) : 1;
  localparam int unsigned RowCntW  = $clog2(ROWS_PER_FRAME + 1);
  localparam logic [2:0]          LastByte = 3'(BYTES_PER_ROW - 1);
  localparam logic [LineCntW-1:0] LastLine = LineCntW'(LINE_REPEAT - 1);
  localparam logic [RowCntW-1:0]  LastRow  = RowCntW'(ROWS_PER_FRAME - 1);

  fetch_state_e        state_q, state_d;
  logic [LineCntW-1:0] line_cnt_q, line_cnt_d;
  logic [RowCntW-1:0]  row_cnt_q, row_cnt_d;
  logic [2:0]          byte_cnt_q, byte_cnt_d;
  logic [15:0]         mem_addr_q, mem_addr_d;
  logic                wr_bank_q, wr_bank_d;
  logic                rd_bank_q, rd_bank_d;
  logic                row_valid_q, row_valid_d;
  logic                overrun_q, overrun_d;
  logic                disp_en_q, disp_en_d;
  logic                dmao_q, dmao_d;

  logic dma_cycle, capture, row_full, line_wrap, buf_we;

  // Display enable strobes; disp_on wins when both arrive together.
  always_comb begin
    disp_en_d = disp_en_q;
    if (bus.clk_enable) begin
      if (disp_on) begin
        disp_en_d = 1'b1;
      end else if (disp_off) begin
        disp_en_d = 1'b0;
      end
    end
  end

  assign dma_cycle = bus.clk_enable && (bus.SC == SC_DMA);
  assign line_wrap = (line_cnt_q == LastLine);

  // Fetch FSM next-state, counters, bank swap and DMA request.
  always_comb begin
    state_d     = state_q;
    line_cnt_d  = line_cnt_q;
    row_cnt_d   = row_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    mem_addr_d  = mem_addr_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    row_valid_d = row_valid_q;
    overrun_d   = overrun_q;
    buf_we      = 1'b0;
    capture     = 1'b0;
    row_full    = 1'b0;

    if (!disp_en_d) begin
      // Disabling drops straight to idle; buffer contents are kept but invalid.
      state_d     = StIdle;
      row_valid_d = 1'b0;
      line_cnt_d  = '0;
      row_cnt_d   = '0;
      byte_cnt_d  = '0;
      mem_addr_d  = START_ADDR;
    end else if (frame_start) begin
      // Frame start restarts the frame from any state and masks line_start.
      state_d     = StArm;
      row_valid_d = 1'b0;
      line_cnt_d  = '0;
      row_cnt_d   = '0;
      byte_cnt_d  = '0;
      mem_addr_d  = START_ADDR;
    end else begin
      capture  = (state_q == StFetch) && dma_cycle;
      row_full = capture && (byte_cnt_q == LastByte);
      if (capture) begin
        buf_we     = 1'b1;
        byte_cnt_d = byte_cnt_q + 3'd1;
        mem_addr_d = next_addr(mem_addr_q);
        if (row_full) begin
          state_d = StDone;
        end
      end

      if (line_start && (state_q != StIdle)) begin
        line_cnt_d = line_wrap ? '0 : line_cnt_q + 1'b1;
        case (state_q)
          StArm: begin
            if (line_cnt_q == '0) begin
              state_d = StFetch;
            end
          end
          StFetch, StDone: begin
            if (line_wrap) begin
              // End of row group: swap banks whether or not the row finished.
              rd_bank_d  = wr_bank_q;
              wr_bank_d  = ~wr_bank_q;
              byte_cnt_d = '0;
              row_cnt_d  = row_cnt_q + 1'b1;
              if ((state_q == StDone) || row_full) begin
                row_valid_d = 1'b1;
              end else begin
                row_valid_d = 1'b0;
                overrun_d   = 1'b1;
              end
              if (row_cnt_q == LastRow) begin
                state_d    = StIdle;
                row_cnt_d  = '0;
                mem_addr_d = START_ADDR;
              end else begin
                state_d = StFetch;
              end
            end
          end
          default: ;
        endcase
      end
    end

    dmao_d = (state_d != StFetch);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      line_cnt_q  <= '0;
      row_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      mem_addr_q  <= START_ADDR;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      row_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      disp_en_q   <= 1'b0;
      dmao_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      line_cnt_q  <= line_cnt_d;
      row_cnt_q   <= row_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      mem_addr_q  <= mem_addr_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      row_valid_q <= row_valid_d;
      overrun_q   <= overrun_d;
      disp_en_q   <= disp_en_d;
      dmao_q      <= dmao_d;
    end
  end

  pixie_row_buffer u_row_buffer (
    .clk     (clk),
    .we      (buf_we),
    .wr_bank (wr_bank_q),
    .wr_idx  (byte_cnt_q),
    .wr_data (bus.data_in),
    .rd_bank (rd_bank_q),
    .rd_idx  (rd_idx),
    .rd_data (row_byte)
  );

  assign bus.DMAO        = dmao_q;
  assign bus.mem_addr    = mem_addr_q;
  assign row_valid       = row_valid_q;
  assign display_enabled = disp_en_q;
  assign overrun         = overrun_q;

endmodule

// File: tb/tb_pixie_dma_fetch.sv
// Bench for pixie_dma_fetch: a display-enable vector table plus directed
// sequences; captured row bytes are checked through a byte scoreboard.
module tb_pixie_dma_fetch;

  logic       clk;
  logic       reset;
  logic       disp_on;
  logic       disp_off;
  logic       frame_start;
  logic       line_start;
  logic [2:0] rd_idx;
  logic [7:0] row_byte;
  logic       row_valid;
  logic       display_enabled;
  logic       overrun;

  int checks   = 0;
  int failures = 0;

  logic [7:0] sb [$];

  pixie_dma_fetch_if bus ();

  pixie_dma_fetch dut (
    .clk             (clk),
    .reset           (reset),
    .bus             (bus),
    .disp_on         (disp_on),
    .disp_off        (disp_off),
    .frame_start     (frame_start),
    .line_start      (line_start),
    .rd_idx          (rd_idx),
    .row_byte        (row_byte),
    .row_valid       (row_valid),
    .display_enabled (display_enabled),
    .overrun         (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic ce;
    logic on;
    logic off;
    logic exp_en;
  } en_vec_t;

  en_vec_t vecs [7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic dma(input logic [7:0] d, input bit push);
    bus.clk_enable = 1'b1;
    bus.SC         = 2'b10;
    bus.data_in    = d;
    if (push) sb.push_back(d);
    step();
    bus.clk_enable = 1'b0;
    bus.SC         = 2'b00;
  endtask

  task automatic bus_cycle(input logic [1:0] sc, input logic [7:0] d);
    bus.clk_enable = 1'b1;
    bus.SC         = sc;
    bus.data_in    = d;
    step();
    bus.clk_enable = 1'b0;
    bus.SC         = 2'b00;
  endtask

  task automatic pulse_line();
    line_start = 1'b1;
    step();
    line_start = 1'b0;
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic strobe(input logic on, input logic off);
    bus.clk_enable = 1'b1;
    disp_on        = on;
    disp_off       = off;
    step();
    bus.clk_enable = 1'b0;
    disp_on        = 1'b0;
    disp_off       = 1'b0;
  endtask

  // Read the displayed bank and compare against the oldest scoreboard row.
  task automatic check_row(input string name);
    check({name, "_valid"}, 16'(row_valid), 16'h1);
    for (int i = 0; i < 8; i++) begin
      rd_idx = 3'(i);
      #1;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL %s: scoreboard empty at byte %0d, got %0h", name, i, row_byte);
      end else begin
        check(name, 16'(row_byte), 16'(sb.pop_front()));
      end
    end
  endtask

  initial begin
    logic [7:0] d;
    int         n;
    int         nls;

    vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b0};

    reset          = 1'b1;
    disp_on        = 1'b0;
    disp_off       = 1'b0;
    frame_start    = 1'b0;
    line_start     = 1'b0;
    rd_idx         = 3'd0;
    bus.clk_enable = 1'b0;
    bus.SC         = 2'b00;
    bus.data_in    = 8'h00;

    // Reset values
    #2 reset = 1'b0;
    step();
    step();
    check("rst_dmao", 16'(bus.DMAO), 16'h1);
    check("rst_valid", 16'(row_valid), 16'h0);
    check("rst_en", 16'(display_enabled), 16'h0);
    check("rst_overrun", 16'(overrun), 16'h0);
    check("rst_addr", bus.mem_addr, 16'h0900);
    reset = 1'b1;
    step();

    // Display-enable strobe table
    for (int v = 0; v < 7; v++) begin
      bus.clk_enable = vecs[v].ce;
      disp_on        = vecs[v].on;
      disp_off       = vecs[v].off;
      step();
      bus.clk_enable = 1'b0;
      disp_on        = 1'b0;
      disp_off       = 1'b0;
      check($sformatf("en_vec%0d", v), 16'(display_enabled), 16'(vecs[v].exp_en));
      check($sformatf("en_vec%0d_dmao", v), 16'(bus.DMAO), 16'h1);
    end

    // First row: 8 DMA cycles, displayed after the group ends
    strobe(1'b1, 1'b0);
    pulse_frame();
    check("arm_dmao", 16'(bus.DMAO), 16'h1);
    pulse_line();
    for (int i = 0; i < 8; i++) begin
      check($sformatf("fetch_dmao_low%0d", i), 16'(bus.DMAO), 16'h0);
      dma(8'((i + 1) * 8'h11), 1'b1);
    end
    check("row0_dmao_high", 16'(bus.DMAO), 16'h1);
    check("row0_addr", bus.mem_addr, 16'h0908);
    pulse_line();
    check("group0_valid_a", 16'(row_valid), 16'h0);
    pulse_line();
    check("group0_valid_b", 16'(row_valid), 16'h0);
    pulse_line();
    check("swap0_valid", 16'(row_valid), 16'h1);
    check("swap0_dmao", 16'(bus.DMAO), 16'h0);
    pulse_line();
    check_row("row0");

    // Deadline miss: only 5 bytes before the group ends
    for (int i = 0; i < 5; i++) dma(8'hA0 + 8'(i), 1'b0);
    pulse_line();
    pulse_line();
    check("pre_miss_overrun", 16'(overrun), 16'h0);
    pulse_line();
    check("miss_overrun", 16'(overrun), 16'h1);
    check("miss_valid", 16'(row_valid), 16'h0);
    check("miss_dmao", 16'(bus.DMAO), 16'h0);
    check("miss_addr", bus.mem_addr, 16'h090D);

    // Refetch from byte 0 with non-DMA cycles interleaved, then DMA in DONE
    for (int i = 0; i < 8; i++) begin
      bus_cycle(2'b00, 8'hDD);
      dma(8'hB0 + 8'(i), 1'b1);
    end
    check("refetch_addr", bus.mem_addr, 16'h0915);
    check("refetch_dmao", 16'(bus.DMAO), 16'h1);
    for (int i = 0; i < 3; i++) dma(8'hEE, 1'b0);
    check("done_dma_addr", bus.mem_addr, 16'h0915);
    for (int i = 0; i < 4; i++) pulse_line();
    check_row("row_refetch");
    check("overrun_sticky", 16'(overrun), 16'h1);

    // Display disabled mid-fetch
    dma(8'h77, 1'b0);
    dma(8'h78, 1'b0);
    strobe(1'b0, 1'b1);
    check("off_dmao", 16'(bus.DMAO), 16'h1);
    check("off_en", 16'(display_enabled), 16'h0);
    check("off_valid", 16'(row_valid), 16'h0);
    check("off_addr", bus.mem_addr, 16'h0900);
    strobe(1'b1, 1'b0);
    pulse_line();
    check("idle_needs_frame", 16'(bus.DMAO), 16'h1);

    // Asynchronous reset mid-fetch
    pulse_frame();
    pulse_line();
    dma(8'h01, 1'b0);
    dma(8'h02, 1'b0);
    check("pre_rst_dmao", 16'(bus.DMAO), 16'h0);
    check("pre_rst_addr", bus.mem_addr, 16'h0902);
    #2 reset = 1'b0;
    #1;
    check("async_rst_dmao", 16'(bus.DMAO), 16'h1);
    check("async_rst_addr", bus.mem_addr, 16'h0900);
    check("async_rst_valid", 16'(row_valid), 16'h0);
    check("async_rst_overrun", 16'(overrun), 16'h0);
    #2 reset = 1'b1;
    step();

    // Full frame; frame_start and line_start together -> frame_start wins
    strobe(1'b1, 1'b0);
    frame_start = 1'b1;
    line_start  = 1'b1;
    step();
    frame_start = 1'b0;
    line_start  = 1'b0;
    check("frame_prio_dmao", 16'(bus.DMAO), 16'h1);
    pulse_line();
    check("frame_fetch_dmao", 16'(bus.DMAO), 16'h0);
    for (int r = 0; r < 32; r++) begin
      for (int i = 0; i < 8; i++) begin
        d = 8'(r * 8 + i) ^ 8'h5A;
        dma(d, 1'b1);
        n = r * 8 + i + 1;
        if (n == 255) check("addr_09ff", bus.mem_addr, 16'h09FF);
        if (n == 256) check("addr_wrap", bus.mem_addr, 16'h0900);
      end
      nls = (r == 0) ? 3 : 4;
      for (int k = 0; k < nls; k++) pulse_line();
      check_row($sformatf("frame_row%0d", r));
      check($sformatf("frame_dmao%0d", r), 16'(bus.DMAO), (r == 31) ? 16'h1 : 16'h0);
    end
    pulse_line();
    check("frame_end_idle", 16'(bus.DMAO), 16'h1);
    check("frame_end_overrun", 16'(overrun), 16'h0);
    check("frame_end_addr", bus.mem_addr, 16'h0900);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
